// File: rtl/gray_codec_pipe.sv
// Registered binary<->Gray converter with one-word output buffer and a
// Gray-adjacency checker that counts steps whose Hamming distance is not one.
module gray_codec_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             step_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] bin_to_gray;
    logic [WIDTH-1:0] gray_to_bin;
    logic [WIDTH-1:0] conv;
    logic [WIDTH-1:0] gray_val;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prev_gray;
    logic             has_prev;
    logic             one_hot;
    logic             err_next;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign bin_to_gray = in_data ^ (in_data >> 1);

    always_comb begin
        gray_to_bin = '0;
        gray_to_bin[WIDTH-1] = in_data[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            gray_to_bin[WIDTH-1-k] = gray_to_bin[WIDTH-k] ^ in_data[WIDTH-1-k];
        end
    end

    assign conv     = mode ? gray_to_bin : bin_to_gray;
    assign gray_val = mode ? in_data : bin_to_gray;

    // Distance is exactly one iff the XOR is non-zero with a single bit set.
    assign diff     = gray_val ^ prev_gray;
    assign one_hot  = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    assign err_next = has_prev && !clr && !one_hot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            step_err  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= conv;
            step_err  <= err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            has_prev  <= 1'b0;
        end else if (accept) begin
            prev_gray <= gray_val;
            has_prev  <= 1'b1;
        end else if (clr) begin
            has_prev  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (accept && err_next && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
